// File: rtl/ram_sync_clr.sv
// ---------------------------------------------------------------------------
// ram_sync_clr
//   Synchronous single-port scratch RAM with a valid/ready request port,
//   per-byte write enables and a registered one-cycle read response. A clear
//   engine writes CLEAR_VALUE to every word after reset and whenever
//   clear_start_i is pulsed while idle. The request port is closed while the
//   clear engine runs.
//
// Parameters
//   addr_size    address width in bits
//   word_size    data width in bits (multiple of 8)
//   memory_size  number of words (<= 2**addr_size)
//   CLEAR_VALUE  word written to every location by the clear engine
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   req_valid_i    request present
//   req_ready_o    request accepted when req_valid_i && req_ready_o
//   req_wr_i       1 = write, 0 = read
//   req_addr_i     word address
//   req_wdata_i    write data
//   req_be_i       byte enables, bit i selects byte [8i+7:8i]
//   rsp_valid_o    one-cycle read response strobe
//   rsp_rdata_o    read data, held until the next response
//   rsp_err_o      response was for an out-of-range address
//   clear_start_i  request a full clear (pulse, honoured only when idle)
//   busy_o         clear engine running
// ---------------------------------------------------------------------------
module ram_sync_clr #(
    parameter int                   addr_size   = 10,
    parameter int                   word_size   = 8,
    parameter int                   memory_size = 1024,
    parameter logic [word_size-1:0] CLEAR_VALUE = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_wr_i,
    input  logic [addr_size-1:0]     req_addr_i,
    input  logic [word_size-1:0]     req_wdata_i,
    input  logic [word_size/8-1:0]   req_be_i,
    output logic                     rsp_valid_o,
    output logic [word_size-1:0]     rsp_rdata_o,
    output logic                     rsp_err_o,
    input  logic                     clear_start_i,
    output logic                     busy_o
);

    localparam int BYTES = word_size / 8;
    localparam int IDX_W = (memory_size > 1) ? $clog2(memory_size) : 1;
    // One bit wider than the address so memory_size == 2**addr_size still fits.
    localparam logic [addr_size:0]   MEM_LIMIT = (addr_size + 1)'(memory_size);
    localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(memory_size - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [addr_size-1:0]   ptr_q, ptr_d;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    // Forces rsp_rdata_o to zero after reset and after an out-of-range read,
    // so the lane read registers themselves need no reset.
    logic                   rd_zero_q;

    logic                   in_range;
    logic                   req_fire;
    logic                   rd_fire;
    logic                   rd_en;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic [word_size-1:0]   wr_data;
    logic [BYTES-1:0]       wr_be;
    logic [word_size-1:0]   rd_word;

    // ------------------------------------------------------------------
    // Request handshake
    // ------------------------------------------------------------------
    assign in_range    = {1'b0, req_addr_i} < MEM_LIMIT;
    // clear_start_i wins over a same-cycle request.
    assign req_ready_o = (state_q == ST_IDLE) && !clear_start_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign rd_fire     = req_fire && !req_wr_i;
    assign rd_en       = rd_fire && in_range;
    assign rd_idx      = req_addr_i[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Clear engine FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                // Stop on the last word; the pointer never wraps.
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_start_i) begin
                    ptr_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Single write port shared by the clear engine and the request port.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ptr_q[IDX_W-1:0];
        wr_data = CLEAR_VALUE;
        wr_be   = '1;
        if (state_q == ST_CLEAR) begin
            wr_en = 1'b1;
        end else if (req_fire && req_wr_i && in_range) begin
            wr_en   = 1'b1;
            wr_idx  = req_addr_i[IDX_W-1:0];
            wr_data = req_wdata_i;
            wr_be   = req_be_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rd_fire;
            if (rd_fire) begin
                rsp_err_q <= !in_range;
                rd_zero_q <= !in_range;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane, each with its own write
    // enable and a registered read that only updates on an in-range read.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] mem [0:memory_size-1];
            logic [7:0] rd_q;

            always_ff @(posedge clk_i) begin
                if (wr_en && wr_be[gi]) begin
                    mem[wr_idx] <= wr_data[8*gi +: 8];
                end
                if (rd_en) begin
                    rd_q <= mem[rd_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rd_zero_q ? '0 : rd_word;
    assign busy_o      = (state_q == ST_CLEAR);

endmodule
